// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: state encoding,
// word width, default reset address and the buffered entry layout.
package fetch_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = 2 * WORD_W;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush. The head entry, count, full and empty are all
// flops, so a pushed word is visible at the head the cycle after the push.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_s, wr_ptr_s;
    logic [PTR_W:0]   count_r, count_s;
    logic [WIDTH-1:0] head_r, head_s;
    logic             full_r, empty_r;
    logic             push_s, pop_s;

    // Next pointers/occupancy; flush wins over any push or pop in the same cycle.
    always_comb begin
        pop_s  = pop && !flush && !empty_r;
        push_s = push && !flush && (!full_r || pop_s);
        if (flush) begin
            rd_ptr_s = {PTR_W{1'b0}};
            wr_ptr_s = {PTR_W{1'b0}};
            count_s  = {(PTR_W+1){1'b0}};
        end else begin
            rd_ptr_s = rd_ptr_r + PTR_W'(pop_s);
            wr_ptr_s = wr_ptr_r + PTR_W'(push_s);
            count_s  = count_r + (PTR_W+1)'(push_s) - (PTR_W+1)'(pop_s);
        end
        // The new head may be the word being written this very cycle.
        if (count_s == {(PTR_W+1){1'b0}}) begin
            head_s = head_r;
        end else if (push_s && (wr_ptr_r == rd_ptr_s)) begin
            head_s = wdata;
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
    end

    // Control and head registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
            head_r   <= {WIDTH{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            rd_ptr_r <= rd_ptr_s;
            wr_ptr_r <= wr_ptr_s;
            count_r  <= count_s;
            head_r   <= head_s;
            full_r   <= (count_s == DEPTH_C);
            empty_r  <= (count_s == {(PTR_W+1){1'b0}});
        end
    end

    // Storage array, not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign head  = head_r;
    assign count = count_r;
    assign full  = full_r;
    assign empty = empty_r;
endmodule

// File: rtl/fetch_fifo_chk.sv
// Protocol checker for the fetch FIFO: a push into a full FIFO is only legal
// when the head leaves in the same cycle.
module fetch_fifo_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic full
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: walks a word-addressed PC, issues one memory request at a
// time over req/ack, buffers responses and hands them to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_target,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [WORD_W-1:0] inst_data,
    output logic [WORD_W-1:0] inst_pc,
    input  logic              inst_ready
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = DEPTH[CNT_W-1:0];

    fetch_state_e      state_r, state_s;
    logic [WORD_W-1:0] fetch_pc_r, fetch_pc_s, addr_r, addr_s;
    logic              req_r;
    logic              ack_s, push_s, pop_s, space_s;
    logic [CNT_W-1:0]  fifo_count_s, proj_s;
    logic              fifo_full_s, fifo_empty_s;
    fetch_entry_t      wentry_s, head_s;

    // Next fetch state, fetch PC and request address.
    always_comb begin
        state_s       = state_r;
        fetch_pc_s    = fetch_pc_r;
        ack_s         = imem_ack && (state_r != ST_IDLE);
        pop_s         = !fifo_empty_s && inst_ready;
        push_s        = (state_r == ST_REQ) && ack_s && !redirect_valid;
        wentry_s.pc   = fetch_pc_r;
        wentry_s.inst = imem_rdata;
        proj_s        = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
        space_s       = (proj_s < DEPTH_C);
        case (state_r)
            ST_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_s = redirect_target;
                    state_s    = ST_REQ;
                end else if (space_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    fetch_pc_s = redirect_target;
                    state_s    = ack_s ? ST_REQ : ST_DRAIN;
                end else if (ack_s) begin
                    fetch_pc_s = fetch_pc_r + 32'd1;
                    state_s    = space_s ? ST_REQ : ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // The outstanding response belongs to a flushed address.
                if (redirect_valid) begin
                    fetch_pc_s = redirect_target;
                    state_s    = ack_s ? ST_REQ : ST_DRAIN;
                end else if (ack_s) begin
                    state_s = space_s ? ST_REQ : ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                fetch_pc_s = fetch_pc_r;
            end
        endcase
        addr_s = (state_s == ST_REQ) ? fetch_pc_s : addr_r;
    end

    // Fetch FSM and registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            addr_r     <= RESET_PC;
            req_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            addr_r     <= addr_s;
            req_r      <= (state_s != ST_IDLE);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push_s),
        .wdata (wentry_s),
        .pop   (pop_s),
        .head  (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    fetch_fifo_chk u_fifo_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .pop  (pop_s && !redirect_valid),
        .full (fifo_full_s)
    );

    assign imem_req   = req_r;
    assign imem_addr  = addr_r;
    assign inst_valid = !fifo_empty_s;
    assign inst_data  = head_s.inst;
    assign inst_pc    = head_s.pc;
endmodule
